// File: rtl/xadac_vmacc_pipe.sv
// xadac_vmacc_pipe: three-stage vector multiply-accumulate execute unit.
//   Each SumWidth lane of vs3 is accumulated with a dot product of up to Epl element pairs taken
//   from vs1/vs2. Each instruction selects signed or unsigned arithmetic and wrap or saturate.
//   S1 registers element products, S2 registers per-lane reductions, S3 adds vs3, clamps and
//   holds the response. All stages shift together whenever the output register can move.
// Ports:
//   clk_i, rst_ni               clock, synchronous active-low reset
//   req_valid/req_ready         request handshake (req_ready = advance)
//   req_id, req_imm, req_mode   id, group length, {saturate, signed}
//   req_vs1/vs2/vs3             multiplicand, multiplier, accumulator vectors
//   resp_valid/resp_ready       response handshake
//   resp_id, resp_vd, resp_rd   echoed id, result vector, scalar result (always 0)
module xadac_vmacc_pipe #(
    parameter int unsigned VectorWidth = 128,
    parameter int unsigned SumWidth    = 32,
    parameter int unsigned ElemWidth   = 8,
    parameter int unsigned IdWidth     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [IdWidth-1:0]     req_id,
    input  logic [7:0]             req_imm,
    input  logic [1:0]             req_mode,
    input  logic [VectorWidth-1:0] req_vs1,
    input  logic [VectorWidth-1:0] req_vs2,
    input  logic [VectorWidth-1:0] req_vs3,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IdWidth-1:0]     resp_id,
    output logic [VectorWidth-1:0] resp_vd,
    output logic [31:0]            resp_rd
);

    localparam int unsigned Lanes = VectorWidth / SumWidth;
    localparam int unsigned Epl   = SumWidth / ElemWidth;
    localparam int unsigned Elems = Lanes * Epl;
    // Two extra bits hold both the unsigned*unsigned and signed*signed product ranges.
    localparam int unsigned ProdW = 2 * ElemWidth + 2;
    localparam int unsigned FullW = SumWidth + 2 * ElemWidth + $clog2(Epl) + 1;

    localparam logic signed [FullW-1:0] SMax =
        {{(FullW - SumWidth + 1){1'b0}}, {(SumWidth - 1){1'b1}}};
    localparam logic signed [FullW-1:0] SMin =
        {{(FullW - SumWidth + 1){1'b1}}, {(SumWidth - 1){1'b0}}};
    localparam logic signed [FullW-1:0] UMax =
        {{(FullW - SumWidth){1'b0}}, {SumWidth{1'b1}}};

    function automatic logic signed [ProdW-1:0] ext_elem(input logic [ElemWidth-1:0] e,
                                                         input logic sx);
        return {{(ProdW - ElemWidth){sx & e[ElemWidth-1]}}, e};
    endfunction

    // Pipeline state
    logic                    s1_valid_q, s2_valid_q, s3_valid_q;
    logic [IdWidth-1:0]      s1_id_q, s2_id_q, s3_id_q;
    logic [1:0]              s1_mode_q, s2_mode_q;
    logic [VectorWidth-1:0]  s1_vs3_q, s2_vs3_q, s3_vd_q;
    logic signed [ProdW-1:0] s1_prod_q [Elems];
    logic signed [FullW-1:0] s2_sum_q [Lanes];

    logic                    advance;
    logic [31:0]             len;
    logic signed [ProdW-1:0] prod_d [Elems];
    logic signed [FullW-1:0] sum_d [Lanes];
    logic signed [FullW-1:0] acc [Lanes];
    logic [VectorWidth-1:0]  vd_d;

    assign advance    = !s3_valid_q || resp_ready;
    assign req_ready  = advance;
    assign resp_valid = s3_valid_q;
    assign resp_id    = s3_id_q;
    assign resp_vd    = s3_vd_q;
    assign resp_rd    = '0;

    // S1: element products; elements beyond the group length contribute zero, so len never
    // needs to travel further down the pipe.
    always_comb begin
        len = (32'(req_imm) > Epl) ? Epl : 32'(req_imm);
        for (int unsigned i = 0; i < Lanes; i++) begin
            for (int unsigned j = 0; j < Epl; j++) begin
                prod_d[i*Epl+j] = '0;
                if (j < len) begin
                    prod_d[i*Epl+j] =
                        ext_elem(req_vs1[ElemWidth*(i*Epl+j) +: ElemWidth], req_mode[0]) *
                        ext_elem(req_vs2[ElemWidth*(i*Epl+j) +: ElemWidth], req_mode[0]);
                end
            end
        end
    end

    // S2: per-lane reduction at full exact width.
    always_comb begin
        for (int unsigned i = 0; i < Lanes; i++) begin
            sum_d[i] = '0;
            for (int unsigned j = 0; j < Epl; j++) begin
                sum_d[i] = sum_d[i] +
                    {{(FullW - ProdW){s1_prod_q[i*Epl+j][ProdW-1]}}, s1_prod_q[i*Epl+j]};
            end
        end
    end

    // S3: add the accumulator lane, then wrap or clamp.
    always_comb begin
        vd_d = '0;
        for (int unsigned i = 0; i < Lanes; i++) begin
            acc[i] = s2_sum_q[i] +
                {{(FullW - SumWidth){s2_mode_q[0] & s2_vs3_q[SumWidth*i+SumWidth-1]}},
                 s2_vs3_q[SumWidth*i +: SumWidth]};
            vd_d[SumWidth*i +: SumWidth] = acc[i][SumWidth-1:0];
            if (s2_mode_q[1]) begin
                if (s2_mode_q[0]) begin
                    if (acc[i] > SMax) begin
                        vd_d[SumWidth*i +: SumWidth] = SMax[SumWidth-1:0];
                    end else if (acc[i] < SMin) begin
                        vd_d[SumWidth*i +: SumWidth] = SMin[SumWidth-1:0];
                    end
                end else begin
                    if (acc[i] > UMax) begin
                        vd_d[SumWidth*i +: SumWidth] = UMax[SumWidth-1:0];
                    end else if (acc[i] < 0) begin
                        vd_d[SumWidth*i +: SumWidth] = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s2_id_q    <= '0;
            s3_id_q    <= '0;
            s1_mode_q  <= '0;
            s2_mode_q  <= '0;
            s1_vs3_q   <= '0;
            s2_vs3_q   <= '0;
            s3_vd_q    <= '0;
            for (int unsigned k = 0; k < Elems; k++) s1_prod_q[k] <= '0;
            for (int unsigned i = 0; i < Lanes; i++) s2_sum_q[i] <= '0;
        end else if (advance) begin
            // Whole pipe moves as one; bubbles travel along with valid ops.
            s1_valid_q <= req_valid;
            s1_id_q    <= req_id;
            s1_mode_q  <= req_mode;
            s1_vs3_q   <= req_vs3;
            for (int unsigned k = 0; k < Elems; k++) s1_prod_q[k] <= prod_d[k];
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
            s2_mode_q  <= s1_mode_q;
            s2_vs3_q   <= s1_vs3_q;
            for (int unsigned i = 0; i < Lanes; i++) s2_sum_q[i] <= sum_d[i];
            s3_valid_q <= s2_valid_q;
            s3_id_q    <= s2_id_q;
            s3_vd_q    <= vd_d;
        end
    end

endmodule

// File: tb/tb_xadac_vmacc_pipe.sv
// Directed bench for xadac_vmacc_pipe at default parameters (4 lanes x 4 byte elements).
module tb_xadac_vmacc_pipe;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_id = '0;
    logic [7:0]   req_imm = '0;
    logic [1:0]   req_mode = '0;
    logic [127:0] req_vs1 = '0;
    logic [127:0] req_vs2 = '0;
    logic [127:0] req_vs3 = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [3:0]   resp_id;
    logic [127:0] resp_vd;
    logic [31:0]  resp_rd;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    xadac_vmacc_pipe dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_id     (req_id),
        .req_imm    (req_imm),
        .req_mode   (req_mode),
        .req_vs1    (req_vs1),
        .req_vs2    (req_vs2),
        .req_vs3    (req_vs3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_vd    (resp_vd),
        .resp_rd    (resp_rd)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rep_e(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [127:0] rep_l(input logic [31:0] w);
        return {4{w}};
    endfunction

    // Single op through an empty pipe; called and returns at a negedge.
    task automatic run_op(input string tag, input logic [3:0] id, input logic [7:0] imm,
                          input logic [1:0] mode, input logic [127:0] v1,
                          input logic [127:0] v2, input logic [127:0] v3,
                          input logic [127:0] exp);
        int lat;
        req_valid = 1'b1;
        req_id    = id;
        req_imm   = imm;
        req_mode  = mode;
        req_vs1   = v1;
        req_vs2   = v2;
        req_vs3   = v3;
        resp_ready = 1'b1;
        lat = 0;
        @(posedge clk_i);
        lat++;
        @(negedge clk_i);
        // Scramble the request after acceptance; the op in flight must not notice.
        req_valid = 1'b0;
        req_id    = ~id;
        req_imm   = 8'd0;
        req_mode  = ~mode;
        req_vs1   = ~v1;
        req_vs3   = ~v3;
        while (!resp_valid && lat < 20) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        check_eq({tag, "_lat"}, 128'(lat), 128'd3);
        check_eq({tag, "_vd"}, resp_vd, exp);
        check_eq({tag, "_id"}, 128'(resp_id), 128'(id));
        check_eq({tag, "_rd"}, 128'(resp_rd), 128'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        check_eq({tag, "_drain"}, 128'(resp_valid), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] ramp;
        logic [127:0] prev_vd;
        logic [3:0]   prev_id;
        logic         stalled_prev;
        logic         acc;
        int           cyc;
        int           sent;
        int           got;
        int           seen;

        for (int k = 0; k < 16; k++) ramp[8*k +: 8] = 8'(k + 1);

        // Reset
        repeat (2) @(negedge clk_i);
        check_eq("rst_valid", 128'(resp_valid), 128'd0);
        check_eq("rst_id", 128'(resp_id), 128'd0);
        check_eq("rst_vd", resp_vd, 128'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Latency and basic unsigned MAC: 4*(1*2)+10 = 18
        run_op("t1", 4'd3, 8'd4, 2'b00, rep_e(8'h01), rep_e(8'h02), rep_l(32'd10),
               rep_l(32'd18));
        // Distinct per-lane values: lane i = sum of (4i+j+1)
        run_op("lanes4", 4'd1, 8'd4, 2'b00, ramp, rep_e(8'h01), 128'd0,
               {32'd58, 32'd42, 32'd26, 32'd10});
        run_op("lanes3", 4'd2, 8'd3, 2'b00, ramp, rep_e(8'h01), 128'd0,
               {32'd42, 32'd30, 32'd18, 32'd6});

        // Signedness
        run_op("t2_s", 4'd4, 8'd4, 2'b01, rep_e(8'hFF), rep_e(8'h03), 128'd0,
               rep_l(32'hFFFF_FFF4));
        run_op("t2_u", 4'd5, 8'd4, 2'b00, rep_e(8'hFF), rep_e(8'h03), 128'd0,
               rep_l(32'h0000_0BF4));

        // Group length
        run_op("t3_len2", 4'd6, 8'd2, 2'b00, rep_e(8'h02), rep_e(8'h02), 128'd0,
               rep_l(32'd8));
        run_op("t3_len0", 4'd7, 8'd0, 2'b01, rep_e(8'h02), rep_e(8'h02),
               128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
               128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        run_op("t3_len9", 4'd8, 8'd9, 2'b00, rep_e(8'h02), rep_e(8'h02), 128'd0,
               rep_l(32'd16));

        // Saturation and wrap at both ends of both ranges
        run_op("t4_ssat", 4'd9, 8'd4, 2'b11, rep_e(8'h7F), rep_e(8'h7F), rep_l(32'h7FFF_FFF0),
               rep_l(32'h7FFF_FFFF));
        run_op("t4_swrap", 4'd10, 8'd4, 2'b01, rep_e(8'h7F), rep_e(8'h7F),
               rep_l(32'h7FFF_FFF0), rep_l(32'h8000_FBF4));
        run_op("t4_ssatneg", 4'd11, 8'd4, 2'b11, rep_e(8'h80), rep_e(8'h7F),
               rep_l(32'h8000_0010), rep_l(32'h8000_0000));
        run_op("t4_swrapneg", 4'd12, 8'd4, 2'b01, rep_e(8'h80), rep_e(8'h7F),
               rep_l(32'h8000_0010), rep_l(32'h7FFF_0210));
        run_op("t4_usat", 4'd13, 8'd4, 2'b10, rep_e(8'h7F), rep_e(8'h7F),
               rep_l(32'hFFFF_FFF0), rep_l(32'hFFFF_FFFF));
        run_op("t4_uwrap", 4'd14, 8'd4, 2'b00, rep_e(8'h7F), rep_e(8'h7F),
               rep_l(32'hFFFF_FFF0), rep_l(32'h0000_FBF4));

        // Back-pressure: op n gives lanes 4*(n+1)+n
        cyc = 0;
        sent = 0;
        got = 0;
        stalled_prev = 1'b0;
        prev_vd = '0;
        prev_id = '0;
        while (got < 6 && cyc < 100) begin
            resp_ready = !(cyc >= 4 && cyc < 8);
            req_valid  = (sent < 6);
            req_id     = 4'(sent);
            req_imm    = 8'd4;
            req_mode   = 2'b00;
            req_vs1    = rep_e(8'(sent + 1));
            req_vs2    = rep_e(8'h01);
            req_vs3    = rep_l(32'(sent));
            #1;
            acc = req_valid && req_ready;
            if (resp_valid && !resp_ready) begin
                check_eq("bp_req_ready", 128'(req_ready), 128'd0);
                if (stalled_prev) begin
                    check_eq("bp_hold_vd", resp_vd, prev_vd);
                    check_eq("bp_hold_id", 128'(resp_id), 128'(prev_id));
                end
                prev_vd = resp_vd;
                prev_id = resp_id;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (resp_valid && resp_ready) begin
                check_eq("bp_id", 128'(resp_id), 128'(got));
                check_eq("bp_vd", resp_vd, rep_l(32'(5 * got + 4)));
                got++;
            end
            @(negedge clk_i);
            if (acc) sent++;
            cyc++;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        check_eq("bp_count", 128'(got), 128'd6);
        seen = 0;
        repeat (6) begin
            @(negedge clk_i);
            if (resp_valid) seen++;
        end
        check_eq("bp_no_dup", 128'(seen), 128'd0);

        // Reset with three ops in flight, output stalled so none is taken
        resp_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            req_valid = 1'b1;
            req_id    = 4'(7 + n);
            req_imm   = 8'd4;
            req_mode  = 2'b00;
            req_vs1   = rep_e(8'h01);
            req_vs2   = rep_e(8'h01);
            req_vs3   = 128'd0;
            @(negedge clk_i);
        end
        req_valid = 1'b0;
        rst_ni    = 1'b0;
        @(negedge clk_i);
        check_eq("t6_valid", 128'(resp_valid), 128'd0);
        check_eq("t6_id", 128'(resp_id), 128'd0);
        check_eq("t6_vd", resp_vd, 128'd0);
        rst_ni     = 1'b1;
        resp_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk_i);
            if (resp_valid) seen++;
        end
        check_eq("t6_dropped", 128'(seen), 128'd0);
        run_op("t6_after", 4'd15, 8'd4, 2'b00, rep_e(8'h01), rep_e(8'h02), rep_l(32'd10),
               rep_l(32'd18));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
